// File: rtl/seq_shift_add_mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_shift_add_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// Operand capture (with optional polarity inversion) and the shift-add step:
// accumulator, left-shifting multiplicand and right-shifting multiplier.
module seq_mul_datapath
  import seq_shift_add_mul_pkg::*;
#(
  parameter int WIDTH            = 4,
  parameter bit INPUT_ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         step,
  input  logic [WIDTH-1:0]             a_in,
  input  logic [WIDTH-1:0]             b_in,
  output logic [prod_width(WIDTH)-1:0] acc
);

  localparam int PW = prod_width(WIDTH);

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mreg;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;

  // Board buttons pull low when pressed, so a pressed button reads as a 1 bit.
  assign a_cap = INPUT_ACTIVE_LOW ? ~a_in : a_in;
  assign b_cap = INPUT_ACTIVE_LOW ? ~b_in : b_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mreg  <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= PW'(a_cap);
      mreg  <= b_cap;
    end else if (step) begin
      if (mreg[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      mreg  <= mreg >> 1;
    end
  end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential unsigned multiplier: IDLE/RUN/DONE control, step counter and
// registered busy/done/product outputs around the shift-add datapath.
module seq_shift_add_mul
  import seq_shift_add_mul_pkg::*;
#(
  parameter int WIDTH            = 4,
  parameter bit INPUT_ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a_in,
  input  logic [WIDTH-1:0]             b_in,
  output logic                         busy,
  output logic                         done,
  output logic [prod_width(WIDTH)-1:0] product
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          load;
  logic          step;
  logic [PW-1:0] acc;

  seq_mul_datapath #(
    .WIDTH            (WIDTH),
    .INPUT_ACTIVE_LOW (INPUT_ACTIVE_LOW)
  ) u_datapath (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a_in (a_in),
    .b_in (b_in),
    .acc  (acc)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy follows the state being entered so it is high exactly for RUN cycles;
  // product is loaded only while leaving DONE and otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state == DONE);
      if (state == DONE) product <= acc;
      if (load)      cnt <= CW'(WIDTH);
      else if (step) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed bench for seq_shift_add_mul at WIDTH=2 (active-low), 8 and 4.
module tb_seq_shift_add_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=2, active-low operands (button style)
  logic       rst2, start2, busy2, done2;
  logic [1:0] a2, b2;
  logic [3:0] p2;
  // WIDTH=8, active-high operands
  logic        rst8, start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  // WIDTH=4, active-high operands
  logic       rst4, start4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  seq_shift_add_mul #(.WIDTH(2), .INPUT_ACTIVE_LOW(1'b1)) u_mul2 (
    .clk(clk), .rst(rst2), .start(start2), .a_in(a2), .b_in(b2),
    .busy(busy2), .done(done2), .product(p2));

  seq_shift_add_mul #(.WIDTH(8), .INPUT_ACTIVE_LOW(1'b0)) u_mul8 (
    .clk(clk), .rst(rst8), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .product(p8));

  seq_shift_add_mul #(.WIDTH(4), .INPUT_ACTIVE_LOW(1'b0)) u_mul4 (
    .clk(clk), .rst(rst4), .start(start4), .a_in(a4), .b_in(b4),
    .busy(busy4), .done(done4), .product(p4));

  // Launch one multiply on the 2-bit unit; lat = edges from accept to the
  // first edge after which done is seen (-1 if it never comes).
  task automatic run2(input logic [1:0] a, input logic [1:0] b, output int lat);
    lat = -1;
    a2 = a; b2 = b; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done2) begin lat = i; break; end
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat);
    lat = -1;
    a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done4) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst8 = 1'b1; rst4 = 1'b1;
    start2 = 1'b1; start8 = 1'b1; start4 = 1'b1;
    a2 = '0; b2 = '0; a8 = '1; b8 = '1; a4 = '1; b4 = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy2, done2} !== 2'b00) begin errors++; $display("FAIL reset_ctl2 got %b want 00", {busy2, done2}); end
    checks++; if (p2 !== 4'h0) begin errors++; $display("FAIL reset_prod2 got %h want 0", p2); end
    checks++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL reset_ctl8 got %b want 00", {busy8, done8}); end
    checks++; if (p8 !== 16'h0) begin errors++; $display("FAIL reset_prod8 got %h want 0", p8); end
    checks++; if ({busy4, done4} !== 2'b00) begin errors++; $display("FAIL reset_ctl4 got %b want 00", {busy4, done4}); end
    checks++; if (p4 !== 8'h0) begin errors++; $display("FAIL reset_prod4 got %h want 0", p4); end
    start2 = 1'b0; start8 = 1'b0; start4 = 1'b0;
    rst2 = 1'b0; rst8 = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;
  endtask

  // All buttons pressed (3x3) and all released (0x0) on the active-low unit.
  task automatic test_buttons();
    int lat;
    run2(2'b00, 2'b00, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL w2_latency got %0d want 3", lat); end
    checks++; if (p2 !== 4'b1001) begin errors++; $display("FAIL w2_3x3 got %b want 1001", p2); end
    @(posedge clk); #1;
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL w2_done_pulse got %b want 0", done2); end
    run2(2'b11, 2'b11, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL w2_latency_0x0 got %0d want 3", lat); end
    checks++; if (p2 !== 4'h0) begin errors++; $display("FAIL w2_0x0 got %h want 0", p2); end
  endtask

  // Every 2-bit input pair; button value is 3 - raw input.
  task automatic test_exhaustive2();
    int lat;
    logic [3:0] exp;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        exp = 4'((3 - a) * (3 - b));
        run2(2'(a), 2'(b), lat);
        checks++;
        if (lat !== 3 || p2 !== exp) begin
          errors++;
          $display("FAIL w2_pair a=%0d b=%0d got %h lat %0d want %h lat 3", a, b, p2, lat, exp);
        end
      end
    end
  endtask

  // 255x255 on the 8-bit unit: latency and busy length.
  task automatic test_wide();
    int lat, busy_cycles, done_cycles;
    lat = -1; busy_cycles = 0; done_cycles = 0;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL w8_busy_after_accept got %b want 1", busy8); end
    for (int i = 1; i <= 14; i++) begin
      if (busy8) busy_cycles++;
      @(posedge clk); #1;
      if (done8) begin
        done_cycles++;
        if (lat < 0) lat = i;
      end
    end
    checks++; if (lat !== 9) begin errors++; $display("FAIL w8_latency got %0d want 9", lat); end
    checks++; if (busy_cycles !== 8) begin errors++; $display("FAIL w8_busy_len got %0d want 8", busy_cycles); end
    checks++; if (done_cycles !== 1) begin errors++; $display("FAIL w8_done_count got %0d want 1", done_cycles); end
    checks++; if (p8 !== 16'hFE01) begin errors++; $display("FAIL w8_ffxff got %h want fe01", p8); end
  endtask

  // Second start during RUN with changed operands must be ignored.
  task automatic test_start_while_busy();
    int lat, done_cycles;
    lat = -1; done_cycles = 0;
    a4 = 4'd5; b4 = 4'd7; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin a4 = 4'd15; b4 = 4'd15; start4 = 1'b1; end
      if (i == 3) start4 = 1'b0;
      if (done4) begin
        done_cycles++;
        if (lat < 0) lat = i;
      end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL w4_latency got %0d want 5", lat); end
    checks++; if (done_cycles !== 1) begin errors++; $display("FAIL w4_ignored_start dones got %0d want 1", done_cycles); end
    checks++; if (p4 !== 8'd35) begin errors++; $display("FAIL w4_5x7 got %0d want 35", p4); end
  endtask

  // Reset during RUN aborts silently and clears product; next run is clean.
  task automatic test_abort();
    int lat, done_cycles;
    done_cycles = 0;
    a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy4); end
    checks++; if (p4 !== 8'd0) begin errors++; $display("FAIL abort_prod got %0d want 0", p4); end
    for (int i = 0; i < 8; i++) begin
      if (done4) done_cycles++;
      @(posedge clk); #1;
    end
    checks++; if (done_cycles !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cycles); end
    run4(4'd9, 4'd9, lat);
    checks++; if (lat !== 5 || p4 !== 8'd81) begin errors++; $display("FAIL abort_rerun got %0d lat %0d want 81 lat 5", p4, lat); end
  endtask

  // start held high: two back-to-back multiplies, second uses new operands.
  task automatic test_back_to_back();
    int first, second, done_cycles;
    bit unstable;
    first = -1; second = -1; done_cycles = 0; unstable = 1'b0;
    a4 = 4'd3; b4 = 4'd4; start4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'd2; b4 = 4'd6;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done4) begin
        done_cycles++;
        if (first < 0) first = i; else second = i;
      end
      if (first > 0 && p4 !== 8'd12) unstable = 1'b1;
      if (i == 11) start4 = 1'b0;
    end
    checks++; if (first !== 5) begin errors++; $display("FAIL b2b_first got %0d want 5", first); end
    checks++; if (second - first !== 6) begin errors++; $display("FAIL b2b_spacing got %0d want 6", second - first); end
    checks++; if (done_cycles !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cycles); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL b2b_prod_stable got %b want 0", unstable); end
    checks++; if (p4 !== 8'd12) begin errors++; $display("FAIL b2b_prod got %0d want 12", p4); end
  endtask

  initial begin
    test_reset();
    test_buttons();
    test_exhaustive2();
    test_wide();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
